// File: rtl/pkt_gen_pkg.sv
// -----------------------------------------------------------------------------
// pkt_gen_pkg
// Shared types and helpers for the packet generator.
//   state_t     : generator FSM states (IDLE, SEND, GAP)
//   SEQ_W       : width of the packet sequence number carried in the payload
//   BEATIDX_W   : width of the beat index carried in the payload
//   calc_beats  : beats per packet = ceil(len / bytes_per_beat), len 0 -> 1
//   calc_empty  : unused bytes in the final beat
// -----------------------------------------------------------------------------
package pkt_gen_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2
  } state_t;

  localparam int SEQ_W     = 32;
  localparam int BEATIDX_W = 16;

  // Bytes per beat is a power of two, so the ceiling division is an add
  // and a shift.
  function automatic logic [BEATIDX_W-1:0] calc_beats(input logic [31:0] len,
                                                      input int unsigned log2_bytes);
    logic [31:0] l;
    logic [31:0] mask;
    l          = (len == 32'd0) ? 32'd1 : len;
    mask       = (32'd1 << log2_bytes) - 32'd1;
    calc_beats = BEATIDX_W'((l + mask) >> log2_bytes);
  endfunction

  // (bytes - len mod bytes) mod bytes == (-len) mod bytes.
  function automatic logic [31:0] calc_empty(input logic [31:0] len,
                                             input int unsigned log2_bytes);
    logic [31:0] l;
    logic [31:0] mask;
    l          = (len == 32'd0) ? 32'd1 : len;
    mask       = (32'd1 << log2_bytes) - 32'd1;
    calc_empty = (32'd0 - l) & mask;
  endfunction

endpackage

// File: rtl/pkt_gen_beat_ctr.sv
// -----------------------------------------------------------------------------
// pkt_gen_beat_ctr
// Per-packet beat counter with last-beat and empty decode.
//   clk, rst     : clock, asynchronous active-low reset
//   i_len        : latched packet length in bytes (0 treated as 1)
//   i_clear      : restart the count at beat 0 (new run)
//   i_adv        : current beat accepted by the sink
//   o_beat_idx   : index of the beat currently presented
//   o_last       : current beat is the final beat of the packet
//   o_empty      : unused bytes in the final beat
// The counter wraps to 0 when the last beat is accepted, so it is already
// positioned on beat 0 of the following packet.
// -----------------------------------------------------------------------------
module pkt_gen_beat_ctr
  import pkt_gen_pkg::*;
#(
  parameter int DWIDTH  = 512,
  parameter int EMPTY_W = 6,
  parameter int LEN_W   = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [LEN_W-1:0]     i_len,
  input  logic                 i_clear,
  input  logic                 i_adv,
  output logic [BEATIDX_W-1:0] o_beat_idx,
  output logic                 o_last,
  output logic [EMPTY_W-1:0]   o_empty
);

  localparam int unsigned LOG2_BYTES = $clog2(DWIDTH / 8);

  logic [BEATIDX_W-1:0] r_beat;
  logic [BEATIDX_W-1:0] w_beats;

  assign w_beats    = calc_beats(32'(i_len), LOG2_BYTES);
  assign o_last     = (r_beat == (w_beats - BEATIDX_W'(1)));
  assign o_empty    = EMPTY_W'(calc_empty(32'(i_len), LOG2_BYTES));
  assign o_beat_idx = r_beat;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_beat <= '0;
    end else if (i_clear) begin
      r_beat <= '0;
    end else if (i_adv) begin
      r_beat <= o_last ? '0 : r_beat + BEATIDX_W'(1);
    end
  end

endmodule

// File: rtl/pkt_gen.sv
// -----------------------------------------------------------------------------
// pkt_gen
// Packet stream source: emits sop/eop/valid framed packets under ready
// backpressure. Configure cfg_* and pulse start.
// Optional macro: PKT_GEN_ERR_INJECT_EN adds input err_inject; when set at
// start, every packet with seq mod 4 == 3 is sent without its eop flag.
//
// Handshake: a beat transfers on a cycle where out_valid & out_ready are both
// high; while out_valid is high and out_ready low, out_data/sop/eop/empty hold;
// out_valid comes straight from the state register, never from out_ready, and
// stays high for the whole packet.
//
// Ports:
//   clk, rst        : clock, asynchronous active-low reset
//   start, stop     : run start pulse / sticky end-after-current-packet request
//   cfg_num_pkts    : packets per run, 0 = until stop
//   cfg_len         : packet length in bytes (0 -> 1)
//   cfg_gap         : idle cycles between eop and next sop
//   out_data/valid/sop/eop/empty, out_ready : stream source
//   busy            : run in progress
//   done            : one-cycle pulse after the run's final eop is accepted
//   pkts_sent       : accepted final-beat count, cleared only by reset
//   dbg_state       : FSM state for observation
// -----------------------------------------------------------------------------
module pkt_gen
  import pkt_gen_pkg::*;
#(
  parameter int DWIDTH  = 512,
  parameter int EMPTY_W = 6,
  parameter int LEN_W   = 16,
  parameter int GAP_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               stop,
  input  logic [31:0]        cfg_num_pkts,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic [GAP_W-1:0]   cfg_gap,
  output logic [DWIDTH-1:0]  out_data,
  output logic               out_valid,
  output logic               out_sop,
  output logic               out_eop,
  output logic [EMPTY_W-1:0] out_empty,
  input  logic               out_ready,
  output logic               busy,
  output logic               done,
  output logic [31:0]        pkts_sent,
  output state_t             dbg_state
`ifdef PKT_GEN_ERR_INJECT_EN
  ,
  input  logic               err_inject
`endif
);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [LEN_W-1:0]     r_len;
  logic [31:0]          r_num;
  logic [GAP_W-1:0]     r_gap;
  logic [GAP_W-1:0]     r_gap_cnt;
  logic [SEQ_W-1:0]     r_seq;
  logic                 r_stop;
  logic                 r_done;
  logic [31:0]          r_pkts_sent;

  logic                 w_load;
  logic                 w_done_nxt;
  logic                 w_to_gap;
  logic                 w_acc;
  logic                 w_last_acc;
  logic                 w_final;
  logic                 w_end_run;
  logic                 w_eop_mask;
  logic [BEATIDX_W-1:0] w_beat_idx;
  logic                 w_last;
  logic [EMPTY_W-1:0]   w_empty;

`ifdef PKT_GEN_ERR_INJECT_EN
  logic r_err;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)        r_err <= 1'b0;
    else if (w_load) r_err <= err_inject;
  end
  assign w_eop_mask = r_err && (r_seq[1:0] == 2'b11);
`else
  assign w_eop_mask = 1'b0;
`endif

  pkt_gen_beat_ctr #(
    .DWIDTH  (DWIDTH),
    .EMPTY_W (EMPTY_W),
    .LEN_W   (LEN_W)
  ) u_beat_ctr (
    .clk        (clk),
    .rst        (rst),
    .i_len      (r_len),
    .i_clear    (w_load),
    .i_adv      (w_acc),
    .o_beat_idx (w_beat_idx),
    .o_last     (w_last),
    .o_empty    (w_empty)
  );

  assign out_valid  = (r_state == SEND);
  assign w_acc      = out_valid && out_ready;
  assign w_last_acc = w_acc && w_last;
  assign w_final    = (r_num != 32'd0) && (r_seq == (r_num - 32'd1));
  // A stop arriving in the very cycle of the eop accept still ends the run.
  assign w_end_run  = w_final || r_stop || stop;

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_done_nxt  = 1'b0;
    w_to_gap    = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = SEND;
          w_load      = 1'b1;
        end
      end
      SEND: begin
        if (w_last_acc) begin
          if (w_end_run) begin
            w_state_nxt = IDLE;
            w_done_nxt  = 1'b1;
          end else if (r_gap != '0) begin
            w_state_nxt = GAP;
            w_to_gap    = 1'b1;
          end
        end
      end
      GAP: begin
        if (stop || r_stop) begin
          w_state_nxt = IDLE;
          w_done_nxt  = 1'b1;
        end else if (r_gap_cnt == '0) begin
          w_state_nxt = SEND;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_len       <= '0;
      r_num       <= '0;
      r_gap       <= '0;
      r_gap_cnt   <= '0;
      r_seq       <= '0;
      r_stop      <= 1'b0;
      r_done      <= 1'b0;
      r_pkts_sent <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_done_nxt;
      if (w_load) begin
        r_len  <= cfg_len;
        r_num  <= cfg_num_pkts;
        r_gap  <= cfg_gap;
        r_seq  <= '0;
        r_stop <= 1'b0;
      end else begin
        if (stop && (r_state != IDLE)) r_stop <= 1'b1;
        if (w_state_nxt == IDLE)       r_stop <= 1'b0;
        if (w_last_acc)                r_seq  <= r_seq + SEQ_W'(1);
        // Loaded with gap-1 so GAP lasts exactly r_gap cycles.
        if (w_to_gap)
          r_gap_cnt <= r_gap - GAP_W'(1);
        else if ((r_state == GAP) && (r_gap_cnt != '0))
          r_gap_cnt <= r_gap_cnt - GAP_W'(1);
      end
      // Counts final-beat accepts, including ones whose eop flag was masked.
      if (w_last_acc) r_pkts_sent <= r_pkts_sent + 32'd1;
    end
  end

  always_comb begin
    out_data = '0;
    if (out_valid) begin
      out_data[DWIDTH-1 -: SEQ_W]      = r_seq;
      out_data[DWIDTH-33 -: BEATIDX_W] = w_beat_idx;
    end
  end

  assign out_sop   = out_valid && (w_beat_idx == '0);
  assign out_eop   = out_valid && w_last && !w_eop_mask;
  assign out_empty = (out_valid && w_last) ? w_empty : '0;
  assign busy      = (r_state != IDLE);
  assign done      = r_done;
  assign pkts_sent = r_pkts_sent;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_pkt_gen.sv
// -----------------------------------------------------------------------------
// tb_pkt_gen
// Directed bench for pkt_gen. Each run pushes its hand-computed beats into
// exp_q; a negedge monitor pops and compares every accepted beat.
// Expected beat tuple: {sop, eop, empty[5:0], seq[31:0], beat[15:0], rest_zero}.
// -----------------------------------------------------------------------------
module tb_pkt_gen;
  import pkt_gen_pkg::*;

  localparam int DW = 512;
  localparam int EW = 6;
  localparam int XW = 57;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic [31:0]   cfg_num_pkts = '0;
  logic [15:0]   cfg_len = '0;
  logic [7:0]    cfg_gap = '0;
  logic [DW-1:0] out_data;
  logic          out_valid, out_sop, out_eop;
  logic [EW-1:0] out_empty;
  logic          out_ready = 1'b0;
  logic          busy, done;
  logic [31:0]   pkts_sent;
  state_t        dbg_state;
`ifdef PKT_GEN_ERR_INJECT_EN
  logic          err_inject = 1'b0;
`endif

  pkt_gen dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .stop         (stop),
    .cfg_num_pkts (cfg_num_pkts),
    .cfg_len      (cfg_len),
    .cfg_gap      (cfg_gap),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_sop      (out_sop),
    .out_eop      (out_eop),
    .out_empty    (out_empty),
    .out_ready    (out_ready),
    .busy         (busy),
    .done         (done),
    .pkts_sent    (pkts_sent),
    .dbg_state    (dbg_state)
`ifdef PKT_GEN_ERR_INJECT_EN
    ,
    .err_inject   (err_inject)
`endif
  );

  // ---------------- scoreboard state ----------------
  logic [XW-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int done_seen = 0;
  int last_gap = -1;
  int gap_run = 0;
  bit after_eop = 0;
  bit in_pkt = 0;
  bit chk_frame = 1;
  int d0 = 0;

  // ready driver: mode 0 = constant rdy_val, mode 1 = pattern 1,0,0,1
  bit rdy_mode = 0;
  bit rdy_val = 1;
  int ph = 0;
  always @(posedge clk) begin
    #1;
    if (rdy_mode) begin
      out_ready = (ph == 0) || (ph == 3);
      ph = (ph + 1) % 4;
    end else begin
      out_ready = rdy_val;
    end
  end

  function automatic logic [XW-1:0] mk(input bit sop, input bit eop, input int empty,
                                      input int seq, input int idx);
    logic [XW-1:0] v;
    v = {sop, eop, EW'(empty), 32'(seq), 16'(idx), 1'b1};
    return v;
  endfunction

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [XW-1:0] act;
    logic [XW-1:0] exp;
    if (!rst) begin
      in_pkt = 0;
      after_eop = 0;
    end else begin
      if (done) begin
        done_seen++;
        after_eop = 0;
      end
      if (chk_frame && in_pkt) begin
        checks++;
        if (!out_valid) begin
          errors++;
          $display("FAIL valid_drop: out_valid=%0b required=1 mid-packet at %0t", out_valid, $time);
        end
      end
      if (after_eop && out_valid) begin
        last_gap = gap_run;
        after_eop = 0;
      end else if (after_eop) begin
        gap_run++;
      end
      if (out_valid && out_ready) begin
        act = {out_sop, out_eop, out_empty, out_data[DW-1 -: 32], out_data[DW-33 -: 16],
               (out_data[DW-49:0] == '0)};
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL beat_unexpected: got %h, none required", act);
        end else begin
          exp = exp_q.pop_front();
          if (act !== exp) begin
            errors++;
            $display("FAIL beat: got %h required %h", act, exp);
          end
        end
        if (out_sop) in_pkt = 1;
        if (out_eop) begin
          in_pkt = 0;
          after_eop = 1;
          gap_run = 0;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, act, exp);
    end
  endtask

  task automatic push_pkt(input int seq, input int nbeats, input int empty, input bit eop_on);
    for (int b = 0; b < nbeats; b++)
      exp_q.push_back(mk(b == 0, (b == nbeats - 1) && eop_on,
                         (b == nbeats - 1) ? empty : 0, seq, b));
  endtask

  task automatic start_run(input int num, input int len, input int gap, input bit with_stop);
    cfg_num_pkts = 32'(num);
    cfg_len = 16'(len);
    cfg_gap = 8'(gap);
    d0 = done_seen;
    start = 1;
    stop = with_stop;
    tick();
    start = 0;
    stop = 0;
  endtask

  task automatic wait_done(input string name, input int exp_pkts);
    int n;
    n = 0;
    while (done_seen == d0 && n < 3000) begin
      @(posedge clk);
      #2;
      n++;
    end
    if (done_seen == d0) begin
      errors++;
      checks++;
      $display("FAIL %s_timeout: done not seen within %0d cycles", name, n);
    end
    tick(3);
    check({name, "_done_once"}, done_seen - d0, 1);
    check({name, "_busy"}, {31'd0, busy}, 0);
    check({name, "_q_left"}, exp_q.size(), 0);
    check({name, "_pkts_sent"}, pkts_sent, exp_pkts);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int n;
    tick(3);
    check("rst_valid", {31'd0, out_valid}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_done", {31'd0, done}, 0);
    check("rst_pkts", pkts_sent, 0);
    check("rst_data_hi", out_data[DW-1 -: 32], 0);
    rst = 1;
    tick(2);

    // 64-byte single-beat packets, back to back
    for (int s = 0; s < 3; s++) push_pkt(s, 1, 0, 1);
    start_run(3, 64, 0, 0);
    wait_done("t1", 3);
    check("t1_gap", last_gap, 0);

    // 130 bytes: 3 beats, empty 62
    push_pkt(0, 3, 62, 1);
    start_run(1, 130, 0, 0);
    wait_done("t2", 4);

    // 200 bytes: 4 beats, empty 56, ready pattern 1,0,0,1
    rdy_mode = 1;
    tick();
    push_pkt(0, 4, 56, 1);
    push_pkt(1, 4, 56, 1);
    start_run(2, 200, 0, 0);
    wait_done("t3", 6);
    rdy_mode = 0;

    // 65 bytes: 2 beats, empty 63, gap 5; second start while busy is ignored
    push_pkt(0, 2, 63, 1);
    push_pkt(1, 2, 63, 1);
    start_run(2, 65, 5, 0);
    cfg_len = 16'd8;
    cfg_num_pkts = 32'd9;
    start = 1;
    tick();
    start = 0;
    wait_done("t4", 8);
    check("t4_gap", last_gap, 5);

    // unbounded run, stop raised while beat 1 of seq 3 is presented
    for (int s = 0; s < 4; s++) push_pkt(s, 3, 62, 1);
    start_run(0, 130, 0, 0);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(out_valid && out_data[DW-1 -: 32] == 32'd3 && out_data[DW-33 -: 16] == 16'd1)
               && n < 500);
    stop = 1;
    tick();
    stop = 0;
    wait_done("t5", 12);

    // stop during GAP: no further sop
    push_pkt(0, 1, 0, 1);
    start_run(0, 64, 10, 0);
    n = 0;
    while (!(busy && !out_valid) && n < 100) begin
      tick();
      n++;
    end
    stop = 1;
    tick();
    stop = 0;
    wait_done("t6", 13);

    // start and stop together in IDLE: start wins
    push_pkt(0, 1, 0, 1);
    start_run(1, 64, 0, 1);
    wait_done("t7", 14);

    // reset mid-packet while stalled
    rdy_val = 0;
    tick();
    d0 = done_seen;
    cfg_num_pkts = 1;
    cfg_len = 16'd200;
    start = 1;
    tick();
    start = 0;
    tick(3);
    exp_q.delete();
    rst = 0;
    #1;
    check("mid_rst_valid", {31'd0, out_valid}, 0);
    check("mid_rst_sop", {31'd0, out_sop}, 0);
    check("mid_rst_data_hi", out_data[DW-1 -: 32], 0);
    check("mid_rst_busy", {31'd0, busy}, 0);
    check("mid_rst_pkts", pkts_sent, 0);
    tick(2);
    rst = 1;
    rdy_val = 1;
    tick(3);
    check("mid_rst_no_done", done_seen - d0, 0);

`ifdef PKT_GEN_ERR_INJECT_EN
    chk_frame = 0;
    err_inject = 1;
    for (int s = 0; s < 5; s++) push_pkt(s, 1, 0, s != 3);
    start_run(5, 64, 0, 0);
    err_inject = 0;
    wait_done("t8", 5);
    chk_frame = 1;
`else
    push_pkt(0, 1, 0, 1);
    start_run(1, 64, 0, 0);
    wait_done("t8", 1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
